// File: rtl/rst_sequencer_pkg.sv
// rtl/rst_sequencer_pkg.sv - shared state encoding and default constants for the reset sequencer
package rst_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_HOLD     = 2'd0,
        ST_WAIT_ACK = 2'd1,
        ST_GAP      = 2'd2,
        ST_RUN      = 2'd3
    } seq_state_t;

    localparam int DEF_DOMAINS     = 3;
    localparam int DEF_HOLD_CYCLES = 16;
    localparam int DEF_GAP_CYCLES  = 4;
    localparam int DEF_ACK_TIMEOUT = 32;
    localparam int DEF_CNT_W       = 8;

endpackage

// File: rtl/rst_sequencer_counter.sv
// rtl/rst_sequencer_counter.sv - loadable saturating up-counter with terminal-count compare
//
// Ports:
//   clk        counter clock
//   rst_n      asynchronous active-low reset (count -> 0)
//   load       load load_value this cycle (wins over en)
//   load_value value loaded when load is high
//   en         count up by one when not already at term
//   term       terminal-count compare value
//   tc         high while count equals term
module seq_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         en,
    input  logic [W-1:0] term,
    output logic         tc
);

    logic [W-1:0] count;

    assign tc = (count == term);

    // Holding at term instead of wrapping keeps a stalled phase from
    // ever re-arming its own compare.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (en && !tc) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/rst_sequencer.sv
// rtl/rst_sequencer.sv - orders per-domain reset release with hold, gap and acknowledge timeout
//
// Ports:
//   i_clk           always-on sequencer clock
//   i_rst           asynchronous active-low reset
//   i_soft_rst_req  level request; high forces every domain back into reset
//   i_dom_ack       per-domain "reset released" feedback, already synchronous to i_clk
//   o_dom_rst_n     registered active-low reset per domain
//   o_busy          high while the release sequence is in progress
//   o_done          one-cycle pulse once the last domain is acknowledged or timed out
//   o_timeout       sticky per-domain acknowledge-timeout flags
module rst_sequencer
    import rst_sequencer_pkg::*;
#(
    parameter int DOMAINS     = DEF_DOMAINS,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int GAP_CYCLES  = DEF_GAP_CYCLES,
    parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_soft_rst_req,
    input  logic [DOMAINS-1:0] i_dom_ack,
    output logic [DOMAINS-1:0] o_dom_rst_n,
    output logic               o_busy,
    output logic               o_done,
    output logic [DOMAINS-1:0] o_timeout
);

    localparam int               IDX_W    = (DOMAINS > 1) ? $clog2(DOMAINS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DOMAINS - 1);

    seq_state_t         state, state_next;
    logic [IDX_W-1:0]   idx, idx_next;
    logic [DOMAINS-1:0] rst_n_next;
    logic [DOMAINS-1:0] timeout_next;
    logic               busy_next;
    logic               done_next;

    logic               cnt_load;
    logic               cnt_en;
    logic [CNT_W-1:0]   cnt_term;
    logic               cnt_tc;
    logic               ack_sel;

    // One counter serves all three timed phases; only its compare value moves.
    always_comb begin
        cnt_term = CNT_W'(ACK_TIMEOUT - 1);
        case (state)
            ST_HOLD: cnt_term = CNT_W'(HOLD_CYCLES - 1);
            ST_GAP:  cnt_term = CNT_W'(GAP_CYCLES - 1);
            default: cnt_term = CNT_W'(ACK_TIMEOUT - 1);
        endcase
    end

    seq_counter #(
        .W (CNT_W)
    ) u_counter (
        .clk        (i_clk),
        .rst_n      (i_rst),
        .load       (cnt_load),
        .load_value ('0),
        .en         (cnt_en),
        .term       (cnt_term),
        .tc         (cnt_tc)
    );

    // Acknowledge of the domain currently being released; other bits are ignored.
    always_comb begin
        ack_sel = 1'b0;
        for (int d = 0; d < DOMAINS; d++) begin
            if (d == int'(idx)) begin
                ack_sel = i_dom_ack[d];
            end
        end
    end

    always_comb begin
        state_next   = state;
        idx_next     = idx;
        rst_n_next   = o_dom_rst_n;
        timeout_next = o_timeout;
        busy_next    = o_busy;
        done_next    = 1'b0;
        cnt_load     = 1'b0;
        cnt_en       = 1'b0;

        if (i_soft_rst_req) begin
            // Reloading every cycle keeps the hold window measured from the
            // first cycle the request is low.
            state_next   = ST_HOLD;
            idx_next     = '0;
            rst_n_next   = '0;
            timeout_next = '0;
            busy_next    = 1'b1;
            cnt_load     = 1'b1;
        end else begin
            case (state)
                ST_HOLD: begin
                    if (cnt_tc) begin
                        rst_n_next[0] = 1'b1;
                        idx_next      = '0;
                        state_next    = ST_WAIT_ACK;
                        cnt_load      = 1'b1;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
                ST_WAIT_ACK: begin
                    if (ack_sel || cnt_tc) begin
                        if (!ack_sel) begin
                            for (int d = 0; d < DOMAINS; d++) begin
                                if (d == int'(idx)) begin
                                    timeout_next[d] = 1'b1;
                                end
                            end
                        end
                        cnt_load = 1'b1;
                        if (idx == LAST_IDX) begin
                            state_next = ST_RUN;
                            busy_next  = 1'b0;
                            done_next  = 1'b1;
                        end else begin
                            state_next = ST_GAP;
                        end
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
                ST_GAP: begin
                    if (cnt_tc) begin
                        idx_next = idx + 1'b1;
                        for (int d = 0; d < DOMAINS; d++) begin
                            if (d == int'(idx) + 1) begin
                                rst_n_next[d] = 1'b1;
                            end
                        end
                        state_next = ST_WAIT_ACK;
                        cnt_load   = 1'b1;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state       <= ST_HOLD;
            idx         <= '0;
            o_dom_rst_n <= '0;
            o_busy      <= 1'b1;
            o_done      <= 1'b0;
            o_timeout   <= '0;
        end else begin
            state       <= state_next;
            idx         <= idx_next;
            o_dom_rst_n <= rst_n_next;
            o_busy      <= busy_next;
            o_done      <= done_next;
            o_timeout   <= timeout_next;
        end
    end

endmodule

// File: tb/tb_rst_sequencer.sv
// tb/tb_rst_sequencer.sv - scoreboard bench for rst_sequencer
module tb_rst_sequencer;

    localparam int HOLD = 16;
    localparam int GAP  = 4;
    localparam int TMO  = 32;

    localparam int K_FALL = 1;
    localparam int K_REL  = 2;
    localparam int K_BUSY = 3;
    localparam int K_DONE = 4;
    localparam int K_TMO  = 5;

    logic       clk = 1'b0;
    logic       rst_in;
    logic       soft_req;
    logic [2:0] ack_mask;
    logic [2:0] ack_d1 = '0;
    logic [2:0] ack_q  = '0;
    logic [2:0] ack;
    logic [2:0] dom_rst_n;
    logic       busy;
    logic       done;
    logic [2:0] tmo;

    logic       rst1_in;
    logic [0:0] ack1;
    logic [0:0] dom_rst1_n;
    logic       busy1;
    logic       done1;
    logic [0:0] tmo1;

    int         edge_cnt = 0;
    int         checks   = 0;
    int         errors   = 0;
    logic       mon_en   = 1'b0;
    logic [31:0] sb[$];

    logic [2:0] prev_rst  = '0;
    logic       prev_busy = 1'b1;
    logic [2:0] prev_tmo  = '0;

    rst_sequencer #(
        .DOMAINS     (3),
        .HOLD_CYCLES (HOLD),
        .GAP_CYCLES  (GAP),
        .ACK_TIMEOUT (TMO),
        .CNT_W       (8)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst_in),
        .i_soft_rst_req (soft_req),
        .i_dom_ack      (ack),
        .o_dom_rst_n    (dom_rst_n),
        .o_busy         (busy),
        .o_done         (done),
        .o_timeout      (tmo)
    );

    rst_sequencer #(
        .DOMAINS     (1),
        .HOLD_CYCLES (HOLD),
        .GAP_CYCLES  (GAP),
        .ACK_TIMEOUT (TMO),
        .CNT_W       (8)
    ) dut1 (
        .i_clk          (clk),
        .i_rst          (rst1_in),
        .i_soft_rst_req (1'b0),
        .i_dom_ack      (ack1),
        .o_dom_rst_n    (dom_rst1_n),
        .o_busy         (busy1),
        .o_done         (done1),
        .o_timeout      (tmo1)
    );

    assign ack1 = 1'b1;
    assign ack  = ack_q & ack_mask;

    always #5 clk = ~clk;

    // Downstream synchronizer model: each domain acknowledges two cycles after release.
    always @(posedge clk) begin
        edge_cnt <= edge_cnt + 1;
        ack_d1   <= dom_rst_n;
        ack_q    <= ack_d1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ev(input int kind, input int arg, input int cyc);
        return {kind[7:0], arg[7:0], cyc[15:0]};
    endfunction

    task automatic push(input int kind, input int arg, input int cyc);
        sb.push_back(ev(kind, arg, cyc));
    endtask

    task automatic observe(input logic [31:0] e);
        logic [31:0] exp;
        if (sb.size() == 0) begin
            check("unexpected_event", e, 32'h0);
        end else begin
            exp = sb.pop_front();
            check("event", e, exp);
        end
    endtask

    // Event order within one edge: fall, releases ascending, busy, done, timeout.
    always @(negedge clk) begin
        if (mon_en) begin
            if ((prev_rst & ~dom_rst_n) != 3'b000) observe(ev(K_FALL, int'(dom_rst_n), edge_cnt));
            for (int d = 0; d < 3; d++) begin
                if (!prev_rst[d] && dom_rst_n[d]) observe(ev(K_REL, d, edge_cnt));
            end
            if (busy != prev_busy) observe(ev(K_BUSY, int'(busy), edge_cnt));
            if (done) observe(ev(K_DONE, 0, edge_cnt));
            if (tmo != prev_tmo) observe(ev(K_TMO, int'(tmo), edge_cnt));
        end
        prev_rst  = dom_rst_n;
        prev_busy = busy;
        prev_tmo  = tmo;
    end

    // Expected events of a full release sequence whose hold window starts after edge base.
    task automatic push_seq(input int base, input logic [2:0] mask);
        int t;
        int ex;
        logic [2:0] tm;
        tm = 3'b000;
        t  = base + HOLD;
        push(K_REL, 0, t);
        for (int d = 0; d < 3; d++) begin
            ex = mask[d] ? t + 3 : t + TMO;
            if (!mask[d]) tm[d] = 1'b1;
            if (d < 2) begin
                if (!mask[d]) push(K_TMO, int'(tm), ex);
                push(K_REL, d + 1, ex + GAP);
                t = ex + GAP;
            end else begin
                push(K_BUSY, 0, ex);
                push(K_DONE, 0, ex);
                if (!mask[d]) push(K_TMO, int'(tm), ex);
            end
        end
    endtask

    task automatic wait_empty(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check(tag, sb.size(), 0);
        repeat (8) @(negedge clk);
    endtask

    task automatic soft_pulse(input int len, output int base);
        soft_req = 1'b1;
        repeat (len) @(negedge clk);
        soft_req = 1'b0;
        base = edge_cnt;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=stuck exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        int base;
        rst_in   = 1'b0;
        rst1_in  = 1'b0;
        soft_req = 1'b0;
        ack_mask = 3'b111;

        // Power-up: reset state, then full sequence with prompt acknowledges.
        repeat (3) @(negedge clk);
        check("rst_dom", dom_rst_n, 3'b000);
        check("rst_busy", busy, 1'b1);
        check("rst_done", done, 1'b0);
        check("rst_tmo", tmo, 3'b000);
        base   = edge_cnt;
        push_seq(base, 3'b111);
        rst_in = 1'b1;
        mon_en = 1'b1;
        wait_empty("powerup_seq");
        check("run_busy", busy, 1'b0);
        check("run_tmo", tmo, 3'b000);

        // Domain 1 never acknowledges: timeout flag, later domains still released.
        ack_mask = 3'b101;
        b = edge_cnt;
        push(K_FALL, 0, b + 1);
        push(K_BUSY, 1, b + 1);
        soft_pulse(1, base);
        push_seq(base, 3'b101);
        wait_empty("timeout_seq");
        check("tmo_sticky", tmo, 3'b010);

        // Three-cycle soft request in RUN clears timeouts; hold counts from request low.
        ack_mask = 3'b111;
        b = edge_cnt;
        push(K_FALL, 0, b + 1);
        push(K_BUSY, 1, b + 1);
        push(K_TMO, 0, b + 1);
        soft_pulse(3, base);
        push_seq(base, 3'b111);
        wait_empty("soft3_seq");

        // Soft request on the same edge as domain 0 acknowledge: restart wins, no gap.
        b = edge_cnt;
        push(K_FALL, 0, b + 1);
        push(K_BUSY, 1, b + 1);
        push(K_REL, 0, b + 1 + HOLD);
        soft_pulse(1, base);
        while (edge_cnt < base + HOLD + 2) @(negedge clk);
        push(K_FALL, 0, edge_cnt + 1);
        soft_req = 1'b1;
        @(negedge clk);
        soft_req = 1'b0;
        base = edge_cnt;
        push_seq(base, 3'b111);
        wait_empty("soft_vs_ack_seq");

        // Asynchronous reset in the gap after domain 1 timed out.
        ack_mask = 3'b101;
        b = edge_cnt;
        push(K_FALL, 0, b + 1);
        push(K_BUSY, 1, b + 1);
        push(K_REL, 0, b + 1 + HOLD);
        push(K_REL, 1, b + 1 + HOLD + 3 + GAP);
        push(K_TMO, 3'b010, b + 1 + HOLD + 3 + GAP + TMO);
        soft_pulse(1, base);
        while (edge_cnt < b + 1 + HOLD + 3 + GAP + TMO + 2) @(negedge clk);
        check("pre_arst_events", sb.size(), 0);
        mon_en = 1'b0;
        rst_in = 1'b0;
        #1;
        check("arst_dom", dom_rst_n, 3'b000);
        check("arst_busy", busy, 1'b1);
        check("arst_done", done, 1'b0);
        check("arst_tmo", tmo, 3'b000);
        repeat (3) @(negedge clk);
        check("arst_hold_dom", dom_rst_n, 3'b000);
        ack_mask = 3'b111;
        base   = edge_cnt;
        push_seq(base, 3'b111);
        rst_in = 1'b1;
        mon_en = 1'b1;
        wait_empty("replay_seq");

        // Single domain with acknowledge tied high.
        base    = edge_cnt;
        rst1_in = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            check($sformatf("d1_rst_%0d", k), dom_rst1_n, (k >= HOLD) ? 1'b1 : 1'b0);
            check($sformatf("d1_done_%0d", k), done1, (k == HOLD + 1) ? 1'b1 : 1'b0);
            check($sformatf("d1_busy_%0d", k), busy1, (k <= HOLD) ? 1'b1 : 1'b0);
        end
        check("d1_tmo", tmo1, 1'b0);

        check("sb_left", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
